// File: rtl/i2c_pkg.sv
// Shared I2C definitions: master FSM states, quarter-phase index and bus level constants.
// Also used by the i2c_slave benches.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        S_START,
        S_ADDR,
        S_AACK,
        S_WR,
        S_WACK,
        S_RD,
        S_RACK,
        S_STOP
    } state_t;

    typedef enum logic [1:0] {
        PH_Q0,
        PH_Q1,
        PH_Q2,
        PH_Q3
    } qtr_t;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;
    localparam logic ACK      = 1'b0;
    localparam logic NACK     = 1'b1;

endpackage

// File: rtl/i2c_master_if.sv
// Request/response and SDA/SCL signals of the single-byte I2C master.
// The master modport is the controller's view; slave is the requester/bus side.
interface i2c_master_if;

    logic       ENB;
    logic       START;
    logic [6:0] ADDR;
    logic       RW;
    logic [7:0] D;
    logic [7:0] Q;
    logic       BUSY;
    logic       DONE;
    logic       NACK;
    logic       SCL;
    logic       SDA_O;
    logic       SDA_I;

    modport master (
        input  ENB, START, ADDR, RW, D, SDA_I,
        output Q, BUSY, DONE, NACK, SCL, SDA_O
    );

    modport slave (
        output ENB, START, ADDR, RW, D, SDA_I,
        input  Q, BUSY, DONE, NACK, SCL, SDA_O
    );

endinterface

// File: rtl/i2c_tick_gen.sv
// Quarter-slot prescaler: divides CLK by QTR while running and tracks the quarter index.
// Everything freezes while ENB is low; an idle (not running) generator parks at quarter 0.
module i2c_tick_gen
    import i2c_pkg::*;
#(
    parameter int unsigned QTR = 2
) (
    input  logic CLK,
    input  logic RESET,
    input  logic ENB,
    input  logic run,
    output logic tick,
    output qtr_t qtr
);

    localparam int unsigned   CW       = (QTR > 1) ? $clog2(QTR) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(QTR - 1);

    logic [CW-1:0] cnt;

    assign tick = ENB && run && (cnt == CNT_LAST);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt <= '0;
            qtr <= PH_Q0;
        end else if (ENB) begin
            if (!run) begin
                cnt <= '0;
                qtr <= PH_Q0;
            end else if (cnt == CNT_LAST) begin
                cnt <= '0;
                qtr <= qtr_t'(qtr + 2'd1);
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/i2c_master.sv
// Single-byte I2C master: START, address+R/W, one data byte with ACK handling, STOP.
// Bus levels are registered and only updated on quarter boundaries from the tick generator.
module i2c_master
    import i2c_pkg::*;
#(
    parameter int unsigned QTR = 2
) (
    input  logic         CLK,
    input  logic         RESET,
    i2c_master_if.master bus
);

    state_t     state;
    qtr_t       qtr;
    logic       tick;
    logic [2:0] bit_cnt;
    logic [7:0] tx_sr;
    logic [7:0] rx_sr;
    logic [7:0] d_r;
    logic       rw_r;

    i2c_tick_gen #(
        .QTR(QTR)
    ) u_tick (
        .CLK  (CLK),
        .RESET(RESET),
        .ENB  (bus.ENB),
        .run  (bus.BUSY),
        .tick (tick),
        .qtr  (qtr)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            tx_sr     <= '0;
            rx_sr     <= '0;
            d_r       <= '0;
            rw_r      <= RW_WRITE;
            bus.Q     <= '0;
            bus.BUSY  <= 1'b0;
            bus.DONE  <= 1'b0;
            bus.NACK  <= 1'b0;
            bus.SCL   <= 1'b1;
            bus.SDA_O <= 1'b1;
        end else if (bus.ENB) begin
            bus.DONE <= 1'b0;
            if (state == IDLE) begin
                if (bus.START) begin
                    state    <= S_START;
                    bus.BUSY <= 1'b1;
                    bus.NACK <= 1'b0;
                    tx_sr    <= {bus.ADDR, bus.RW};
                    d_r      <= bus.D;
                    rw_r     <= bus.RW;
                    bit_cnt  <= '0;
                end
            end else if (tick) begin
                unique case (qtr)
                    PH_Q0: ;
                    PH_Q1: begin
                        bus.SCL <= 1'b1;
                        if (state == S_START) bus.SDA_O <= 1'b0;
                    end
                    PH_Q2: begin
                        if (state == S_STOP) bus.SDA_O <= 1'b1;
                        if ((state == S_AACK || state == S_WACK) && bus.SDA_I != ACK)
                            bus.NACK <= 1'b1;
                        if (state == S_RD) rx_sr <= {rx_sr[6:0], bus.SDA_I};
                    end
                    PH_Q3: begin
                        // Slot end: pick the next slot and drive its q0 levels.
                        bus.SCL <= 1'b0;
                        unique case (state)
                            S_START: begin
                                state     <= S_ADDR;
                                bus.SDA_O <= tx_sr[7];
                                tx_sr     <= {tx_sr[6:0], 1'b0};
                                bit_cnt   <= '0;
                            end
                            S_ADDR, S_WR: begin
                                bit_cnt <= bit_cnt + 3'd1;
                                if (bit_cnt == 3'd7) begin
                                    state     <= (state == S_ADDR) ? S_AACK : S_WACK;
                                    bus.SDA_O <= 1'b1;
                                end else begin
                                    bus.SDA_O <= tx_sr[7];
                                    tx_sr     <= {tx_sr[6:0], 1'b0};
                                end
                            end
                            S_AACK: begin
                                if (bus.NACK) begin
                                    state     <= S_STOP;
                                    bus.SDA_O <= 1'b0;
                                end else if (rw_r == RW_READ) begin
                                    state     <= S_RD;
                                    bus.SDA_O <= 1'b1;
                                end else begin
                                    state     <= S_WR;
                                    bus.SDA_O <= d_r[7];
                                    tx_sr     <= {d_r[6:0], 1'b0};
                                end
                            end
                            S_RD: begin
                                bit_cnt <= bit_cnt + 3'd1;
                                if (bit_cnt == 3'd7) begin
                                    state     <= S_RACK;
                                    bus.SDA_O <= NACK;
                                    bus.Q     <= rx_sr;
                                end
                            end
                            S_WACK, S_RACK: begin
                                state     <= S_STOP;
                                bus.SDA_O <= 1'b0;
                            end
                            S_STOP: begin
                                state    <= IDLE;
                                bus.SCL  <= 1'b1;
                                bus.BUSY <= 1'b0;
                                bus.DONE <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_master.sv
// Directed bench for i2c_master with a bus-level behavioural I2C slave on the wired-AND SDA.
// Latencies are measured from the accept edge to the cycle DONE is seen high.
module tb_i2c_master;

    localparam int unsigned QTR = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    i2c_master_if bus ();

    i2c_master #(
        .QTR(QTR)
    ) dut (
        .CLK  (clk),
        .RESET(rst),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural slave: decodes START/STOP and SCL edges, ACKs its own address.
    logic       slv_sda   = 1'b1;
    logic       sda;
    logic [6:0] slv_addr  = 7'h2A;
    logic [7:0] slv_tx    = 8'h00;
    logic [7:0] slv_q     = 8'h00;
    logic [7:0] sr        = 8'h00;
    logic [7:0] txs       = 8'h00;
    logic       rw_s      = 1'b0;
    logic       mack      = 1'b0;
    logic       prev_scl  = 1'b1;
    logic       prev_sda  = 1'b1;
    int         sp        = 0;
    int         n         = 0;
    int         scl_rises = 0;

    assign sda       = bus.SDA_O & slv_sda;
    assign bus.SDA_I = sda;

    always @(posedge clk) begin
        prev_scl <= bus.SCL;
        prev_sda <= sda;
        if (bus.SCL && prev_scl && prev_sda && !sda) begin
            sp      <= 1;
            n       <= 0;
            slv_sda <= 1'b1;
        end else if (bus.SCL && prev_scl && !prev_sda && sda) begin
            sp <= 0;
        end else if (!prev_scl && bus.SCL) begin
            scl_rises <= scl_rises + 1;
            if (sp == 1 || sp == 3) begin
                sr <= {sr[6:0], sda};
                n  <= n + 1;
            end else if (sp == 5) begin
                n <= n + 1;
            end else if (sp == 6) begin
                mack <= sda;
            end
        end else if (prev_scl && !bus.SCL) begin
            if (sp == 1 && n == 8) begin
                if (sr[7:1] == slv_addr) begin
                    slv_sda <= 1'b0;
                    rw_s    <= sr[0];
                    sp      <= 2;
                end else begin
                    sp <= 0;
                end
            end else if (sp == 2) begin
                n <= 0;
                if (rw_s) begin
                    sp      <= 5;
                    slv_sda <= slv_tx[7];
                    txs     <= {slv_tx[6:0], 1'b0};
                end else begin
                    sp      <= 3;
                    slv_sda <= 1'b1;
                end
            end else if (sp == 3 && n == 8) begin
                slv_q   <= sr;
                slv_sda <= 1'b0;
                sp      <= 4;
            end else if (sp == 4 || sp == 6) begin
                slv_sda <= 1'b1;
                sp      <= 0;
            end else if (sp == 5) begin
                if (n == 8) begin
                    slv_sda <= 1'b1;
                    sp      <= 6;
                end else begin
                    slv_sda <= txs[7];
                    txs     <= {txs[6:0], 1'b0};
                end
            end
        end
    end

    task automatic launch(input logic [6:0] a, input logic rw, input logic [7:0] d);
        bus.ADDR  = a;
        bus.RW    = rw;
        bus.D     = d;
        bus.START = 1'b1;
        @(posedge clk); #1;
        bus.START = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
            if (bus.DONE === 1'b1) return;
        end
        cyc = -1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.SCL !== 1'b1) begin errors++; $display("FAIL reset_scl got %b want 1", bus.SCL); end
        checks++; if (bus.SDA_O !== 1'b1) begin errors++; $display("FAIL reset_sda got %b want 1", bus.SDA_O); end
        checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.BUSY); end
        checks++; if (bus.DONE !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.DONE); end
        checks++; if (bus.NACK !== 1'b0) begin errors++; $display("FAIL reset_nack got %b want 0", bus.NACK); end
        checks++; if (bus.Q !== 8'h00) begin errors++; $display("FAIL reset_q got %h want 00", bus.Q); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_write();
        int cyc;
        int r0;
        r0 = scl_rises;
        launch(7'h2A, 1'b0, 8'hA5);
        wait_done(cyc);
        checks++; if (cyc !== 160) begin errors++; $display("FAIL wr_latency got %0d want 160", cyc); end
        checks++; if (bus.NACK !== 1'b0) begin errors++; $display("FAIL wr_nack got %b want 0", bus.NACK); end
        checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL wr_busy_at_done got %b want 0", bus.BUSY); end
        checks++; if (slv_q !== 8'hA5) begin errors++; $display("FAIL wr_slave_data got %h want a5", slv_q); end
        checks++; if (scl_rises - r0 !== 19) begin errors++; $display("FAIL wr_scl_pulses got %0d want 19", scl_rises - r0); end
        @(posedge clk); #1;
        checks++; if (bus.DONE !== 1'b0) begin errors++; $display("FAIL wr_done_pulse got %b want 0", bus.DONE); end
    endtask

    task automatic test_read();
        int cyc;
        bit done;
        slv_tx = 8'h3C;
        launch(7'h2A, 1'b1, 8'h00);
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 149) begin
                checks++;
                if (bus.SCL !== 1'b1 || sda !== 1'b1) begin
                    errors++; $display("FAIL rd_master_nack scl=%b sda=%b want 1/1", bus.SCL, sda);
                end
            end
            if (bus.DONE === 1'b1) done = 1'b1;
        end
        checks++; if (cyc !== 160) begin errors++; $display("FAIL rd_latency got %0d want 160", cyc); end
        checks++; if (bus.Q !== 8'h3C) begin errors++; $display("FAIL rd_q got %h want 3c", bus.Q); end
        checks++; if (bus.NACK !== 1'b0) begin errors++; $display("FAIL rd_nack got %b want 0", bus.NACK); end
        checks++; if (mack !== 1'b1) begin errors++; $display("FAIL rd_slave_saw_nack got %b want 1", mack); end
    endtask

    task automatic test_addr_nack();
        int cyc;
        int r0;
        r0 = scl_rises;
        launch(7'h7F, 1'b0, 8'h55);
        wait_done(cyc);
        checks++; if (cyc !== 88) begin errors++; $display("FAIL an_latency got %0d want 88", cyc); end
        checks++; if (bus.NACK !== 1'b1) begin errors++; $display("FAIL an_nack got %b want 1", bus.NACK); end
        checks++; if (scl_rises - r0 !== 10) begin errors++; $display("FAIL an_scl_pulses got %0d want 10", scl_rises - r0); end
        checks++; if (slv_q !== 8'hA5) begin errors++; $display("FAIL an_slave_untouched got %h want a5", slv_q); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        bit done;
        launch(7'h2A, 1'b0, 8'hC3);
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 50) begin
                bus.ADDR  = 7'h7F;
                bus.RW    = 1'b1;
                bus.D     = 8'h00;
                bus.START = 1'b1;
            end else begin
                bus.START = 1'b0;
            end
            if (bus.DONE === 1'b1) done = 1'b1;
        end
        checks++; if (cyc !== 160) begin errors++; $display("FAIL b2b_first_latency got %0d want 160", cyc); end
        checks++; if (bus.NACK !== 1'b0) begin errors++; $display("FAIL b2b_first_nack got %b want 0", bus.NACK); end
        checks++; if (slv_q !== 8'hC3) begin errors++; $display("FAIL b2b_first_data got %h want c3", slv_q); end
        launch(7'h2A, 1'b0, 8'h5A);
        checks++; if (bus.BUSY !== 1'b1) begin errors++; $display("FAIL b2b_second_accept got %b want 1", bus.BUSY); end
        wait_done(cyc);
        checks++; if (cyc !== 160) begin errors++; $display("FAIL b2b_second_latency got %0d want 160", cyc); end
        checks++; if (slv_q !== 8'h5A) begin errors++; $display("FAIL b2b_second_data got %h want 5a", slv_q); end
    endtask

    task automatic test_enb_freeze();
        int cyc;
        bit done;
        bit moved;
        bit busy_drop;
        logic scl_s;
        logic sda_s;
        launch(7'h2A, 1'b0, 8'h96);
        cyc       = 0;
        done      = 1'b0;
        moved     = 1'b0;
        busy_drop = 1'b0;
        scl_s     = 1'b0;
        sda_s     = 1'b0;
        while (!done && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 91) begin
                scl_s   = bus.SCL;
                sda_s   = bus.SDA_O;
                bus.ENB = 1'b0;
            end else if (cyc >= 92 && cyc <= 98) begin
                if (bus.SCL !== scl_s || bus.SDA_O !== sda_s) moved = 1'b1;
                if (bus.BUSY !== 1'b1) busy_drop = 1'b1;
                if (cyc == 98) bus.ENB = 1'b1;
            end
            if (bus.DONE === 1'b1) done = 1'b1;
        end
        checks++; if (moved) begin errors++; $display("FAIL enb_frozen_bus got moved=1 want 0"); end
        checks++; if (busy_drop) begin errors++; $display("FAIL enb_busy_held got drop=1 want 0"); end
        checks++; if (cyc !== 167) begin errors++; $display("FAIL enb_latency got %0d want 167", cyc); end
        checks++; if (slv_q !== 8'h96) begin errors++; $display("FAIL enb_slave_data got %h want 96", slv_q); end
    endtask

    task automatic test_reset_mid();
        int cyc;
        bit bad;
        launch(7'h2A, 1'b1, 8'h00);
        repeat (33) @(posedge clk);
        #1;
        checks++; if (bus.BUSY !== 1'b1 || bus.SCL !== 1'b0) begin
            errors++; $display("FAIL rstmid_pre busy=%b scl=%b want 1/0", bus.BUSY, bus.SCL);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (bus.SCL !== 1'b1) begin errors++; $display("FAIL rstmid_scl got %b want 1", bus.SCL); end
        checks++; if (bus.SDA_O !== 1'b1) begin errors++; $display("FAIL rstmid_sda got %b want 1", bus.SDA_O); end
        checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", bus.BUSY); end
        checks++; if (bus.Q !== 8'h00) begin errors++; $display("FAIL rstmid_q got %h want 00", bus.Q); end
        checks++; if (bus.DONE !== 1'b0) begin errors++; $display("FAIL rstmid_done got %b want 0", bus.DONE); end
        bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.BUSY !== 1'b0 || bus.DONE !== 1'b0 || bus.SCL !== 1'b1 || bus.SDA_O !== 1'b1) bad = 1'b1;
        end
        checks++; if (bad) begin errors++; $display("FAIL rstmid_stays_idle got activity=1 want 0"); end
        launch(7'h2A, 1'b0, 8'h11);
        wait_done(cyc);
        checks++; if (cyc !== 160) begin errors++; $display("FAIL rstmid_recover_latency got %0d want 160", cyc); end
        checks++; if (slv_q !== 8'h11) begin errors++; $display("FAIL rstmid_recover_data got %h want 11", slv_q); end
    endtask

    initial begin
        bus.ENB   = 1'b1;
        bus.START = 1'b0;
        bus.ADDR  = 7'h00;
        bus.RW    = 1'b0;
        bus.D     = 8'h00;
        test_reset();
        test_write();
        test_read();
        test_addr_nack();
        test_back_to_back();
        test_enb_freeze();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish by 200000 time units");
        $fatal(1);
    end

endmodule

// File: doc/i2c_master.md
# i2c_master

Single-byte I2C bus master that sequences complete transactions (START, 7-bit address + R/W, one data byte, ACK handling, STOP) on the open-drain SDA/SCL bus shared with `i2c_slave`. It replaces the hand-driven bus stimulus used so far and is the controller side of the I2C link. A transaction is requested with a one-cycle strobe and finishes with a one-cycle `DONE` pulse.

## Interface
- `QTR`, default 2: CLK cycles per quarter bit-slot; one bit-slot is 4*QTR cycles; legal range ≥1.
- `CLK`  in  1  system clock; all logic on the rising edge.
- `RESET`  in  1  synchronous, active-high reset.
- `ENB`  in  1  enable; when low, all state, counters and outputs hold.
- `START`  in  1  transaction request strobe; sampled only in IDLE.
- `ADDR`  in  7  slave address, latched on accept.
- `RW`  in  1  0 = write `D`, 1 = read into `Q`; latched on accept.
- `D`  in  8  write byte, latched on accept.
- `Q`  out  8  read byte; updated only on a successful read.
- `BUSY`  out  1  high from accept through the end of the STOP slot.
- `DONE`  out  1  one-cycle pulse at transaction end.
- `NACK`  out  1  valid with `DONE`; 1 = slave NACKed address or write byte; holds until next accept.
- `SCL`  out  1  bus clock (master-only, no stretching).
- `SDA_O`  out  1  SDA drive onto the wand net; 0 pulls low, 1 releases.
- `SDA_I`  in  1  resolved SDA level.

## Operation
- Reset values: `SCL`=1, `SDA_O`=1, `BUSY`=0, `DONE`=0, `NACK`=0, `Q`=8'h00, state IDLE, counters 0.
- States: IDLE → S_START → S_ADDR (8 bits: ADDR[6:0] MSB first, then RW) → S_AACK → (RW=0: S_WR 8 bits → S_WACK) / (RW=1: S_RD 8 bits → S_RACK) → S_STOP → IDLE.
- Accept: in IDLE with `ENB`=1 and `START`=1; latch ADDR/RW/D, set `BUSY`, clear `NACK`. `START` while `BUSY` is ignored.
- Each slot has quarters q0..q3 of QTR cycles each. Data/ACK slots: `SCL`=0 in q0,q1 and `SCL`=1 in q2,q3; `SDA_O` changes only at q0 entry; `SDA_I` sampled on the last cycle of q2.
- S_START: `SCL`=1 throughout; `SDA_O`=1 in q0,q1 and 0 in q2,q3 (high→low while SCL high).
- S_STOP: `SDA_O`=0 in q0..q2, 1 in q3; `SCL`=0 in q0,q1, 1 in q2,q3.
- S_AACK/S_WACK: master releases SDA; a sampled 1 sets `NACK` and jumps to S_STOP (skips the data phase after an address NACK).
- S_RD: master releases SDA and shifts `SDA_I` MSB first into a shadow register; S_RACK drives `SDA_O`=1 (master NACK, single byte); `Q` is loaded from the shadow at S_RACK entry.
- End: `DONE` is high for the single cycle after the last S_STOP cycle, `BUSY` drops in that same cycle, and a new `START` is accepted in that cycle.
- RESET mid-transaction: next cycle at reset values, bus released; no STOP is generated.
- ENB low mid-transaction: the phase counter freezes and `SCL`/`SDA_O` hold their levels.

## Timing
- Full transaction = 20 slots = 80*QTR cycles from accept to `DONE` (QTR=2: 160).
- Address-NACK transaction = 11 slots = 44*QTR cycles (QTR=2: 88).
- `SCL` period = 4*QTR cycles with a 50% duty cycle; first `SCL` fall at 4*QTR cycles after accept.
- `SDA_O` never changes while `SCL`=1, except the START and STOP edges.

## Structure
- `i2c_pkg`: state enum, quarter-phase enum, `RW_WRITE`/`RW_READ` and `ACK`/`NACK` level constants; shared with `i2c_slave` benches.
- Sub-module `i2c_tick_gen`: QTR prescaler with `ENB` gating that emits a quarter-end tick and the 2-bit quarter index. Top level holds the FSM, 3-bit bit counter, shift registers, and output registers.

## Test plan
- Write, ADDR matches the `i2c_slave` instance, D=8'hA5, QTR=2 → slave `Q`=8'hA5, `DONE` at accept+160, `NACK`=0.
- Read, slave loaded with 8'h3C → master `Q`=8'h3C at `DONE`; master NACK bit seen as `SDA`=1 in slot 19.
- Unmatched address 7'h7F, SDA pulled up → `NACK`=1, `DONE` at accept+88, no data-phase SCL pulses.
- `START` re-asserted while `BUSY` plus back-to-back `START` in the `DONE` cycle → the first is ignored and the second is accepted with no IDLE gap.
- `ENB` low for 7 cycles mid-S_WR → `SCL`/`SDA_O` frozen, `DONE` delayed by exactly 7 cycles.
- `RESET` during S_ADDR bit 3 → next cycle `SCL`=1, `SDA_O`=1, `BUSY`=0, `Q`=8'h00.
